crypto_seq_ctrl: RTL and testbench

//  Single-clock sequencer in front of the three-stage crypto core.
//  - Accepts one 16-bit block at a time from a host over valid/ready.
//  - Issues a one-cycle core_start with the block and the programmed 5-bit key.
//  - Waits for core_done, with a timeout, then returns the result over valid/ready.
//  - Holds the key configuration register and sticky error flags.

---
 rtl/crypto_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_crypto_seq_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/crypto_seq_ctrl.sv
// Sequencer between a valid/ready host and a three-stage crypto core: launches
// one block at a time, waits for the result with a timeout and returns it.
module crypto_seq_ctrl #(
  parameter int             DATA_W      = 16,
  parameter int             KEY_W       = 5,
  parameter int             TIMEOUT     = 64,
  parameter int             CNT_W       = 16,
  parameter logic [KEY_W-1:0] DEFAULT_KEY = 5'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_key_we,
  input  logic [KEY_W-1:0]  cfg_key,
  input  logic              err_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              core_start,
  output logic [DATA_W-1:0] core_data,
  output logic [KEY_W-1:0]  core_key,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic [1:0]        err,
  output logic [CNT_W-1:0]  blk_count
);

  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [TMR_W-1:0]   timer_r;
  logic [DATA_W-1:0]  core_data_r;
  logic [DATA_W-1:0]  out_data_r;
  logic [KEY_W-1:0]   core_key_r;
  logic [CNT_W-1:0]   blk_count_r;
  logic [1:0]         err_r;
  logic [1:0]         err_next_s;
  logic               in_ready_r;
  logic               busy_r;
  logic               core_start_r;
  logic               out_valid_r;

  logic accept_s;
  logic done_s;
  logic timeout_s;
  logic out_hs_s;
  logic key_wr_s;
  logic key_err_s;

  assign accept_s  = (state_r == IDLE) && in_valid;
  assign done_s    = (state_r == WAIT) && core_done;
  // core_done beats the timeout when both land on the last WAIT cycle
  assign timeout_s = (state_r == WAIT) && !core_done && (timer_r == TMR_LAST);
  assign out_hs_s  = (state_r == DRAIN) && out_ready;
  assign key_wr_s  = cfg_key_we && (state_r == IDLE);
  assign key_err_s = cfg_key_we && (state_r != IDLE);

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_next_s = ISSUE;
        else          state_next_s = IDLE;
      end
      ISSUE: state_next_s = WAIT;
      WAIT: begin
        if (done_s)         state_next_s = DRAIN;
        else if (timeout_s) state_next_s = IDLE;
        else                state_next_s = WAIT;
      end
      DRAIN: begin
        if (out_hs_s) state_next_s = IDLE;
        else          state_next_s = DRAIN;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Sticky error flags: a new event outranks a same-cycle clear
  always_comb begin
    err_next_s = err_r;
    if (timeout_s)    err_next_s[0] = 1'b1;
    else if (err_clr) err_next_s[0] = 1'b0;
    else              err_next_s[0] = err_r[0];
    if (key_err_s)    err_next_s[1] = 1'b1;
    else if (err_clr) err_next_s[1] = 1'b0;
    else              err_next_s[1] = err_r[1];
  end

  // State register and state-decoded output flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      in_ready_r   <= 1'b1;
      busy_r       <= 1'b0;
      core_start_r <= 1'b0;
      out_valid_r  <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      in_ready_r   <= (state_next_s == IDLE);
      busy_r       <= (state_next_s != IDLE);
      core_start_r <= (state_next_s == ISSUE);
      out_valid_r  <= (state_next_s == DRAIN);
    end
  end

  // Datapath: block/result capture, key, timer, counter, errors
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_data_r <= {DATA_W{1'b0}};
      out_data_r  <= {DATA_W{1'b0}};
      core_key_r  <= DEFAULT_KEY;
      timer_r     <= {TMR_W{1'b0}};
      blk_count_r <= {CNT_W{1'b0}};
      err_r       <= 2'b00;
    end else begin
      err_r <= err_next_s;
      if (accept_s) core_data_r <= in_data;
      if (done_s)   out_data_r  <= core_result;
      if (key_wr_s) core_key_r  <= cfg_key;
      if (out_hs_s) blk_count_r <= blk_count_r + CNT_W'(1);
      if (state_r == ISSUE)     timer_r <= {TMR_W{1'b0}};
      else if (state_r == WAIT) timer_r <= timer_r + TMR_W'(1);
      else                      timer_r <= timer_r;
    end
  end

  assign in_ready   = in_ready_r;
  assign busy       = busy_r;
  assign core_start = core_start_r;
  assign out_valid  = out_valid_r;
  assign core_data  = core_data_r;
  assign out_data   = out_data_r;
  assign core_key   = core_key_r;
  assign err        = err_r;
  assign blk_count  = blk_count_r;

endmodule

// File: tb/tb_crypto_seq_ctrl.sv
// Directed bench for crypto_seq_ctrl; a 4-bit counter makes the wrap reachable
// in a short run.
module tb_crypto_seq_ctrl;

  localparam int DATA_W  = 16;
  localparam int KEY_W   = 5;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 4;

  logic              clk;
  logic              rst;
  logic              cfg_key_we;
  logic [KEY_W-1:0]  cfg_key;
  logic              err_clr;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              core_start;
  logic [DATA_W-1:0] core_data;
  logic [KEY_W-1:0]  core_key;
  logic              core_done;
  logic [DATA_W-1:0] core_result;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic [1:0]        err;
  logic [CNT_W-1:0]  blk_count;

  int n_cmp = 0;
  int n_bad = 0;

  crypto_seq_ctrl #(
    .DATA_W(DATA_W), .KEY_W(KEY_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W),
    .DEFAULT_KEY(5'h00)
  ) dut (
    .clk(clk), .rst(rst), .cfg_key_we(cfg_key_we), .cfg_key(cfg_key),
    .err_clr(err_clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .core_start(core_start), .core_data(core_data),
    .core_key(core_key), .core_done(core_done), .core_result(core_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .err(err), .blk_count(blk_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Push one block through with an immediate core response and host accept
  task automatic full_block(input logic [15:0] d, input logic [15:0] r);
    in_data = d; in_valid = 1'b1; tick();
    in_valid = 1'b0; tick();
    core_done = 1'b1; core_result = r; tick();
    core_done = 1'b0; out_ready = 1'b1; tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_key_we = 1'b0; cfg_key = 5'h00; err_clr = 1'b0;
    in_valid = 1'b0; in_data = 16'h0000; core_done = 1'b0;
    core_result = 16'h0000; out_ready = 1'b0;
    #2 rst = 1'b0;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_core_start", 32'(core_start), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_core_key", 32'(core_key), 32'h00);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_blk_count", 32'(blk_count), 32'h0);
    rst = 1'b1;

    // T2 basic
    cfg_key_we = 1'b1; cfg_key = 5'h0A; tick();
    cfg_key_we = 1'b0;
    chk("t2_key", 32'(core_key), 32'h0A);
    in_data = 16'h1234; in_valid = 1'b1; tick();
    in_valid = 1'b0;
    chk("t2_start_hi", 32'(core_start), 32'h1);
    chk("t2_core_data", 32'(core_data), 32'h1234);
    chk("t2_in_ready_lo", 32'(in_ready), 32'h0);
    chk("t2_busy", 32'(busy), 32'h1);
    tick();
    chk("t2_start_lo", 32'(core_start), 32'h0);
    tick(); tick();
    chk("t2_start_lo2", 32'(core_start), 32'h0);
    chk("t2_no_out_yet", 32'(out_valid), 32'h0);
    core_done = 1'b1; core_result = 16'hBEEF; tick();
    core_done = 1'b0;
    chk("t2_out_valid", 32'(out_valid), 32'h1);
    chk("t2_out_data", 32'(out_data), 32'hBEEF);
    chk("t2_count_pre", 32'(blk_count), 32'h0);
    out_ready = 1'b1; tick();
    out_ready = 1'b0;
    chk("t2_out_valid_lo", 32'(out_valid), 32'h0);
    chk("t2_in_ready", 32'(in_ready), 32'h1);
    chk("t2_count", 32'(blk_count), 32'h1);

    // T3 backpressure; core_done and in_valid during DRAIN must be ignored
    in_data = 16'h5555; in_valid = 1'b1; tick();
    in_valid = 1'b0; tick();
    core_done = 1'b1; core_result = 16'hA5A5; tick();
    core_result = 16'h0000; in_valid = 1'b1; in_data = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_out_valid_held", 32'(out_valid), 32'h1);
      chk("t3_out_data_held", 32'(out_data), 32'hA5A5);
      chk("t3_in_ready_lo", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1; tick();
    out_ready = 1'b0; in_valid = 1'b0; core_done = 1'b0;
    chk("t3_count", 32'(blk_count), 32'h2);
    chk("t3_core_data_kept", 32'(core_data), 32'h5555);
    tick();
    chk("t3_count_once", 32'(blk_count), 32'h2);
    chk("t3_idle", 32'(busy), 32'h0);

    // T4 timeout after exactly TIMEOUT WAIT cycles
    in_data = 16'h0F0F; in_valid = 1'b1; tick();
    in_valid = 1'b0; tick();
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      tick();
      chk("t4_no_out", 32'(out_valid), 32'h0);
    end
    chk("t4_still_busy", 32'(busy), 32'h1);
    chk("t4_err_not_yet", 32'(err), 32'h0);
    tick();
    chk("t4_err0", 32'(err), 32'h1);
    chk("t4_idle", 32'(in_ready), 32'h1);
    chk("t4_out_valid", 32'(out_valid), 32'h0);
    chk("t4_count", 32'(blk_count), 32'h2);

    // T5 key write while busy
    in_data = 16'h1111; in_valid = 1'b1; tick();
    in_valid = 1'b0; tick();
    cfg_key_we = 1'b1; cfg_key = 5'h1F; tick();
    cfg_key_we = 1'b0;
    chk("t5_key_kept", 32'(core_key), 32'h0A);
    chk("t5_err", 32'(err), 32'h3);
    core_done = 1'b1; core_result = 16'h2222; tick();
    core_done = 1'b0; out_ready = 1'b1; tick();
    out_ready = 1'b0;
    chk("t5_count", 32'(blk_count), 32'h3);
    err_clr = 1'b1; tick();
    err_clr = 1'b0;
    chk("t5_err_clr", 32'(err), 32'h0);

    // T6 key write with accept, clear/set race, done on the timeout cycle
    cfg_key_we = 1'b1; cfg_key = 5'h15; in_data = 16'hCAFE; in_valid = 1'b1; tick();
    cfg_key_we = 1'b0; in_valid = 1'b0;
    chk("t6_key_same_cycle", 32'(core_key), 32'h15);
    chk("t6_core_data", 32'(core_data), 32'hCAFE);
    tick();
    err_clr = 1'b1; cfg_key_we = 1'b1; cfg_key = 5'h00; tick();
    err_clr = 1'b0; cfg_key_we = 1'b0;
    chk("t6_set_wins", 32'(err), 32'h2);
    chk("t6_key_kept", 32'(core_key), 32'h15);
    for (int i = 0; i < TIMEOUT - 2; i++) tick();
    core_done = 1'b1; core_result = 16'h600D; tick();
    core_done = 1'b0;
    chk("t6_race_valid", 32'(out_valid), 32'h1);
    chk("t6_race_data", 32'(out_data), 32'h600D);
    chk("t6_race_err", 32'(err), 32'h2);
    out_ready = 1'b1; tick();
    out_ready = 1'b0;
    chk("t6_count", 32'(blk_count), 32'h4);
    err_clr = 1'b1; tick();
    err_clr = 1'b0;

    // Counter wrap
    for (int i = 0; i < 11; i++) full_block(16'(i), 16'(16'h7000 + i));
    chk("wrap_pre", 32'(blk_count), 32'hF);
    chk("wrap_last_data", 32'(out_data), 32'h700A);
    full_block(16'h0001, 16'h9999);
    chk("wrap_zero", 32'(blk_count), 32'h0);
    chk("wrap_data", 32'(out_data), 32'h9999);

    // T1 reset mid-WAIT
    in_data = 16'h4321; in_valid = 1'b1; tick();
    in_valid = 1'b0; tick();
    cfg_key_we = 1'b1; cfg_key = 5'h07; tick();
    cfg_key_we = 1'b0; tick();
    #2 rst = 1'b0;
    #1;
    chk("t1_busy", 32'(busy), 32'h0);
    chk("t1_in_ready", 32'(in_ready), 32'h1);
    chk("t1_core_data", 32'(core_data), 32'h0);
    chk("t1_out_data", 32'(out_data), 32'h0);
    chk("t1_err", 32'(err), 32'h0);
    chk("t1_key", 32'(core_key), 32'h00);
    chk("t1_out_valid", 32'(out_valid), 32'h0);
    tick();
    rst = 1'b1;
    core_done = 1'b1; core_result = 16'hDEAD; tick();
    core_done = 1'b0; tick();
    chk("t1_after_valid", 32'(out_valid), 32'h0);
    chk("t1_after_ready", 32'(in_ready), 32'h1);
    chk("t1_after_count", 32'(blk_count), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
